// File: rtl/uart_tx.sv
// Serial transmitter: start bit, LSB-first payload, optional even parity, 1-3 stop bits.
// Timing is driven by an external oversampling strobe; tx is always a flop output.
module uart_tx #(
    parameter int NUM_TICKS     = 16,
    parameter int BITS_PER_DATA = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     tx_start,
    input  logic [BITS_PER_DATA-1:0] d_in,
    input  logic                     parity,
    input  logic [1:0]               stop_bits,
    output logic                     tx,
    output logic                     tx_done,
    output logic                     busy
);

    // Handshake: tx_start is taken on a clk edge only while busy is low; requests
    // while busy are dropped, and tx_done pulses for one clk as the frame ends.

    localparam int SW = $clog2(3 * NUM_TICKS);
    localparam int NW = (BITS_PER_DATA > 1) ? $clog2(BITS_PER_DATA) : 1;

    localparam logic [SW-1:0] BIT_LAST   = SW'(NUM_TICKS - 1);
    localparam logic [SW-1:0] STOP2_LAST = SW'(2 * NUM_TICKS - 1);
    localparam logic [SW-1:0] STOP3_LAST = SW'(3 * NUM_TICKS - 1);
    localparam logic [NW-1:0] DATA_LAST  = NW'(BITS_PER_DATA - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [SW-1:0]            s_q, s_d;
    logic [NW-1:0]            n_q, n_d;
    logic [BITS_PER_DATA-1:0] shreg_q, shreg_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic [1:0]               stop_q, stop_d;
    logic                     tx_q, tx_d;
    logic                     done_q, done_d;
    logic [SW-1:0]            stop_last;

    // Stop period spans k bit times; a latched count of 0 still means one.
    always_comb begin
        stop_last = BIT_LAST;
        case (stop_q)
            2'd2:    stop_last = STOP2_LAST;
            2'd3:    stop_last = STOP3_LAST;
            default: stop_last = BIT_LAST;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop_d    = stop_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shreg_d   = d_in;
                    par_en_d  = parity;
                    par_bit_d = ^d_in;
                    stop_d    = stop_bits;
                    s_d       = '0;
                    n_d       = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == DATA_LAST) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == stop_last) begin
                        s_d     = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    // Line level is derived from the upcoming state so tx moves with the state flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= 2'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign busy    = (state_q != IDLE);

endmodule
